// File: rtl/rv32i_types.sv
// Shared rv32i writeback types: entry kinds and the buffered entry layout.
// Used by wb_arbiter (optional WB_RR_ARB_EN) and wb_chan_fifo.
package rv32i_types;

  localparam int WB_XLEN = 32;

  typedef enum logic [2:0] {
    WB_RAW = 3'd0,
    WB_LB  = 3'd1,
    WB_LBU = 3'd2,
    WB_LH  = 3'd3,
    WB_LHU = 3'd4
  } wb_kind_t;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
    wb_kind_t           kind;
    logic [1:0]         off;
  } wb_entry_t;

  function automatic logic wb_kind_known(logic [2:0] k);
    return k <= 3'(WB_LHU);
  endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel writeback FIFO: synchronous push/pop, async reset,
// synchronous clear. Callers only push when !full and pop when !empty.
module wb_chan_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Multi-channel writeback stage: per-channel FIFOs, one grant per cycle,
// load extract, registered RF port. WB_RR_ARB_EN selects round-robin.
module wb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [NUM_CH-1:0]      in_ready,
  input  logic [NUM_CH*5-1:0]    in_rd,
  input  logic [NUM_CH*XLEN-1:0] in_data,
  input  logic [NUM_CH*3-1:0]    in_kind,
  input  logic [NUM_CH*2-1:0]    in_off,
  input  logic                   flush,
  output logic                   rf_we,
  output logic [4:0]             rf_rd,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   misalign_err,
  output logic                   busy
);

  localparam int EW = 5 + XLEN + 3 + 2;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [EW-1:0]     head [NUM_CH];
  logic              gnt;
  logic [CW-1:0]     gidx;
  logic [4:0]        s_rd;
  logic [XLEN-1:0]   s_data;
  logic [2:0]        s_kind;
  logic [1:0]        s_off;
  logic [XLEN-1:0]   wdata_n;
  logic              mis_n;
  logic [7:0]        b;
  logic [15:0]       h;

  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wb_chan_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata ({in_rd[5*c +: 5], in_data[XLEN*c +: XLEN],
               in_kind[3*c +: 3], in_off[2*c +: 2]}),
      .head  (head[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
    assign pop[c] = gnt && (gidx == CW'(c));
  end

`ifdef WB_RR_ARB_EN
  logic [CW-1:0] ptr;
  int            j;

  // ptr holds the first channel to search this cycle
  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    j    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!gnt && !empty[j] && !flush) begin
        gnt  = 1'b1;
        gidx = CW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (gnt) begin
      ptr <= (gidx == CW'(NUM_CH-1)) ? '0 : gidx + 1'b1;
    end
  end
`else
  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (!empty[i] && !flush) begin
        gnt  = 1'b1;
        gidx = CW'(i);
      end
    end
  end
`endif

  assign {s_rd, s_data, s_kind, s_off} = head[gidx];

  always_comb begin
    b       = s_data[8*s_off +: 8];
    h       = s_data[16*s_off[1] +: 16];
    wdata_n = s_data;
    mis_n   = 1'b0;
    unique case (1'b1)
      (s_kind == WB_LB):
        wdata_n = {{(XLEN-8){b[7]}}, b};
      (s_kind == WB_LBU):
        wdata_n = {{(XLEN-8){1'b0}}, b};
      (s_kind == WB_LH && !s_off[0]):
        wdata_n = {{(XLEN-16){h[15]}}, h};
      (s_kind == WB_LHU && !s_off[0]):
        wdata_n = {{(XLEN-16){1'b0}}, h};
      ((s_kind == WB_LH || s_kind == WB_LHU) && s_off[0]):
        mis_n = 1'b1;
      default: ;
    endcase
  end

  // x0 entries are consumed and registered but never write the RF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_rd        <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
    end else if (gnt) begin
      rf_we        <= (s_rd != 5'd0);
      rf_rd        <= s_rd;
      rf_wdata     <= wdata_n;
      misalign_err <= mis_n;
    end else begin
      rf_we        <= 1'b0;
      misalign_err <= 1'b0;
    end
  end

  assign busy = (|(~empty)) | rf_we;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && gnt)
      assert (wb_kind_known(s_kind))
        else $error("wb_arbiter: unknown writeback kind %0d", s_kind);
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter against a queue-based model.
// Honours WB_RR_ARB_EN when defined for the DUT build.
module tb_wb_arbiter;

  localparam int NCH   = 3;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*5-1:0]  in_rd;
  logic [NCH*32-1:0] in_data;
  logic [NCH*3-1:0]  in_kind;
  logic [NCH*2-1:0]  in_off;
  logic              flush;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [31:0]       rf_wdata;
  logic              misalign_err;
  logic              busy;

  wb_arbiter #(
    .NUM_CH     (NCH),
    .FIFO_DEPTH (DEPTH),
    .XLEN       (XLEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_data      (in_data),
    .in_kind      (in_kind),
    .in_off       (in_off),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .misalign_err (misalign_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rd;
    logic [31:0] data;
    int          kind;
    int          off;
  } ent_t;

  ent_t        q [NCH][$];
  int          checks   = 0;
  int          failures = 0;
  logic        m_we;
  logic        m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  int          m_ptr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] ref_extract(ent_t e, output logic mis);
    logic [31:0] v;
    mis = 1'b0;
    v   = e.data;
    if (e.kind == 1 || e.kind == 2) begin
      v = (e.data >> (8 * e.off)) & 32'hFF;
      if (e.kind == 1 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (e.kind == 3 || e.kind == 4) begin
      if (e.off % 2 == 1) begin
        mis = 1'b1;
      end else begin
        v = (e.data >> (16 * (e.off / 2))) & 32'hFFFF;
        if (e.kind == 3 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) q[c].delete();
    m_we  = 1'b0;
    m_mis = 1'b0;
    m_rd  = '0;
    m_wd  = '0;
    m_ptr = 0;
  endtask

  task automatic set_ch(int c, logic v, int rd, logic [31:0] d, int k, int o);
    in_valid[c]       = v;
    in_rd[5*c +: 5]   = 5'(rd);
    in_data[32*c +: 32] = d;
    in_kind[3*c +: 3] = 3'(k);
    in_off[2*c +: 2]  = 2'(o);
  endtask

  task automatic idle();
    in_valid = '0;
    flush    = 1'b0;
  endtask

  // One clock: check ready, predict the edge, then check outputs.
  task automatic step();
    bit   acc [NCH];
    ent_t nw  [NCH];
    ent_t e;
    int   g;
    int   start;
    int   j;
    bit   any;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("in_ready%0d", c), 32'(in_ready[c]),
          32'(q[c].size() < DEPTH));
      acc[c]     = in_valid[c] && (q[c].size() < DEPTH);
      nw[c].rd   = int'(in_rd[5*c +: 5]);
      nw[c].data = in_data[32*c +: 32];
      nw[c].kind = int'(in_kind[3*c +: 3]);
      nw[c].off  = int'(in_off[2*c +: 2]);
    end
    g = -1;
`ifdef WB_RR_ARB_EN
    start = m_ptr;
`else
    start = 0;
`endif
    if (!flush) begin
      for (int i = 0; i < NCH; i++) begin
        j = (start + i) % NCH;
        if (g < 0 && q[j].size() > 0) g = j;
      end
    end
    @(posedge clk);
    if (flush) begin
      for (int c = 0; c < NCH; c++) q[c].delete();
      m_we  = 1'b0;
      m_mis = 1'b0;
      m_ptr = 0;
    end else begin
      if (g >= 0) begin
        e     = q[g].pop_front();
        m_we  = (e.rd != 0);
        m_rd  = 5'(e.rd);
        m_wd  = ref_extract(e, m_mis);
        m_ptr = (g + 1) % NCH;
      end else begin
        m_we  = 1'b0;
        m_mis = 1'b0;
      end
      for (int c = 0; c < NCH; c++)
        if (acc[c]) q[c].push_back(nw[c]);
    end
    @(negedge clk);
    any = m_we;
    for (int c = 0; c < NCH; c++) if (q[c].size() > 0) any = 1'b1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("rf_rd", 32'(rf_rd), 32'(m_rd));
    chk("rf_wdata", rf_wdata, m_wd);
    chk("busy", 32'(busy), 32'(any));
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'h7);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int exp_order [3];

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_rd    = '0;
    in_data  = '0;
    in_kind  = '0;
    in_off   = '0;
    flush    = 1'b0;
    model_reset();
    #1;
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_rd", 32'(rf_rd), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_mis", 32'(misalign_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'h7);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single LB / LHU on ch1
    set_ch(1, 1'b1, 5, 32'h1280_3456, 1, 2);
    step();
    idle();
    step();
    chk("lb_we", 32'(rf_we), 32'd1);
    chk("lb_rd", 32'(rf_rd), 32'd5);
    chk("lb_data", rf_wdata, 32'hFFFF_FF80);
    set_ch(1, 1'b1, 6, 32'h1280_3456, 4, 2);
    step();
    idle();
    step();
    chk("lhu_data", rf_wdata, 32'h0000_1280);
    step();

    // three-way contention
`ifdef WB_RR_ARB_EN
    exp_order = '{3, 1, 2};
`else
    exp_order = '{1, 2, 3};
`endif
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, c + 1, 32'hA000_0000 + c, 0, 0);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("order%0d", k), 32'(rf_rd), 32'(exp_order[k]));
    end
    step();

    // backpressure: all channels stream for 4 cycles
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < NCH; c++)
        set_ch(c, 1'b1, 10 + 4*c + k, $urandom, 0, 0);
      step();
    end
    idle();
    chk("busy_pre_reset", 32'(busy), 32'd1);
    pulse_reset();

    // misaligned LH and x0 destination
    set_ch(0, 1'b1, 7, 32'hA5A5_8001, 3, 1);
    step();
    idle();
    step();
    chk("mis_flag", 32'(misalign_err), 32'd1);
    chk("mis_data", rf_wdata, 32'hA5A5_8001);
    set_ch(2, 1'b1, 0, 32'h0000_00FF, 1, 0);
    step();
    idle();
    step();
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_busy", 32'(busy), 32'd0);

    // flush with two buffered entries and a same-cycle push
    set_ch(1, 1'b1, 8, 32'h1111_1111, 0, 0);
    set_ch(2, 1'b1, 9, 32'h2222_2222, 0, 0);
    step();
    idle();
    flush = 1'b1;
    set_ch(0, 1'b1, 11, 32'h3333_3333, 0, 0);
    step();
    chk("flush_we", 32'(rf_we), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    idle();
    step();
    chk("flush_drop", 32'(rf_we), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        set_ch(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 19) == 0);
      if (i == 200) begin
        idle();
        pulse_reset();
      end else begin
        step();
      end
    end
    idle();
    for (int i = 0; i < 8; i++) step();
    chk("drained", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
